// File: rtl/pulse_meter_pkg.sv
// Shared types and constants for the pulse meter: FSM state encoding and pulse counter width.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int PCOUNT_W = 16;

endpackage

// File: rtl/pulse_meter_if.sv
// Measurement bundle of the pulse meter: the pulse train in, the measurement results out.
interface pulse_meter_if #(
    parameter int WIDTH = 8
);
    import pulse_meter_pkg::*;

    logic                signal;
    logic                meas_valid;
    logic [WIDTH-1:0]    high_width;
    logic [WIDTH-1:0]    low_width;
    logic [WIDTH:0]      period;
    logic                sat;
    logic [PCOUNT_W-1:0] pulse_count;
    logic                busy;

    modport master (
        input  signal,
        output meas_valid, high_width, low_width, period, sat, pulse_count, busy
    );

    modport slave (
        output signal,
        input  meas_valid, high_width, low_width, period, sat, pulse_count, busy
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an asynchronous level, with registered-delay edge detection.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   warm_q, warm_d;
    logic                   s_dly_q, s_dly_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = async_in;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        s_dly_d = sync_q[SYNC_STAGES-1];
        warm_d  = {warm_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
            warm_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            s_dly_q <= s_dly_d;
            warm_q  <= warm_d;
        end
    end

    // Edges are suppressed until both level and its delayed copy hold real post-reset
    // samples, so an input already high at reset release does not read as a rise.
    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = warm_q[SYNC_STAGES] & level & ~s_dly_q;
    assign fall  = warm_q[SYNC_STAGES] & ~level & s_dly_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high time, low time and period of a synchronised pulse train, one result per
// complete cycle, with saturating counters and a free-running pulse counter.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clock,
    input  logic          reset,
    pulse_meter_if.master bus
);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic s_level, s_rise, s_fall;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    hcnt_q, hcnt_d;
    logic [WIDTH-1:0]    lcnt_q, lcnt_d;
    logic                sat_acc_q, sat_acc_d;
    logic                meas_valid_q, meas_valid_d;
    logic [WIDTH-1:0]    high_width_q, high_width_d;
    logic [WIDTH-1:0]    low_width_q, low_width_d;
    logic [WIDTH:0]      period_q, period_d;
    logic                sat_q, sat_d;
    logic [PCOUNT_W-1:0] pulse_count_q, pulse_count_d;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (bus.signal),
        .level    (s_level),
        .rise     (s_rise),
        .fall     (s_fall)
    );

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        sat_acc_d     = sat_acc_q;
        meas_valid_d  = 1'b0;
        high_width_d  = high_width_q;
        low_width_d   = low_width_q;
        period_d      = period_q;
        sat_d         = sat_q;
        pulse_count_d = pulse_count_q;

        case (state_q)
            ST_WAIT: begin
                if (s_rise) begin
                    state_d   = ST_HIGH;
                    hcnt_d    = CNT_ONE;
                    lcnt_d    = '0;
                    sat_acc_d = 1'b0;
                end
            end
            ST_HIGH: begin
                if (s_fall) begin
                    state_d = ST_LOW;
                    lcnt_d  = CNT_ONE;
                end else if (s_level) begin
                    // sat_acc flags a cycle that could not be counted, not merely reaching max
                    if (hcnt_q == CNT_MAX) sat_acc_d = 1'b1;
                    else                   hcnt_d    = hcnt_q + CNT_ONE;
                end
            end
            ST_LOW: begin
                if (s_rise) begin
                    meas_valid_d  = 1'b1;
                    high_width_d  = hcnt_q;
                    low_width_d   = lcnt_q;
                    period_d      = {1'b0, hcnt_q} + {1'b0, lcnt_q};
                    sat_d         = sat_acc_q;
                    pulse_count_d = pulse_count_q + PCOUNT_W'(1);
                    state_d       = ST_HIGH;
                    hcnt_d        = CNT_ONE;
                    lcnt_d        = '0;
                    sat_acc_d     = 1'b0;
                end else if (lcnt_q == CNT_MAX) begin
                    sat_acc_d = 1'b1;
                end else begin
                    lcnt_d = lcnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            sat_acc_q     <= 1'b0;
            meas_valid_q  <= 1'b0;
            high_width_q  <= '0;
            low_width_q   <= '0;
            period_q      <= '0;
            sat_q         <= 1'b0;
            pulse_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            sat_acc_q     <= sat_acc_d;
            meas_valid_q  <= meas_valid_d;
            high_width_q  <= high_width_d;
            low_width_q   <= low_width_d;
            period_q      <= period_d;
            sat_q         <= sat_d;
            pulse_count_q <= pulse_count_d;
        end
    end

    assign bus.meas_valid  = meas_valid_q;
    assign bus.high_width  = high_width_q;
    assign bus.low_width   = low_width_q;
    assign bus.period      = period_q;
    assign bus.sat         = sat_q;
    assign bus.pulse_count = pulse_count_q;
    assign bus.busy        = (state_q != ST_WAIT);

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter (WIDTH=4 to reach saturation quickly): directed tables, corner
// sequences and randomized pulse trains checked every cycle against a run-length model.
`timescale 1ns/1ps
module tb_pulse_meter;
    import pulse_meter_pkg::*;

    localparam int W    = 4;
    localparam int SS   = 2;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulse_meter_if #(.WIDTH(W)) bus ();

    pulse_meter #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {int hw; int lw; int per; int sat; int cyc;} meas_t;
    meas_t cap_q[$];

    typedef struct {int hi; int lo; int hw; int lw; int per; int sat;} vec_t;
    vec_t vecs[7];

    // Reference model: runs of the synchronised level, counted with unbounded integers
    bit m_busy, m_high;
    int m_hi, m_lo, m_n;
    bit m_smp[$];
    bit e_mv;
    int e_hw, e_lw, e_per, e_sat, e_pc, e_busy;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input bit sig, input bit r);
        bit s, s_d;
        e_mv = 1'b0;
        if (r) begin
            m_busy = 0; m_high = 0; m_hi = 0; m_lo = 0; m_n = 0;
            m_smp.delete();
            e_hw = 0; e_lw = 0; e_per = 0; e_sat = 0; e_pc = 0; e_busy = 0;
            return;
        end
        m_n++;
        m_smp.push_back(sig);
        if (m_smp.size() > 4) void'(m_smp.pop_front());
        // synchronised level lags the sampled input by SS edges; needs a valid previous value too
        if (m_n >= SS + 2) begin
            s_d = m_smp[0];
            s   = m_smp[1];
            if (s && !s_d) begin
                if (m_busy && !m_high) begin
                    e_hw  = (m_hi > MAXV) ? MAXV : m_hi;
                    e_lw  = (m_lo > MAXV) ? MAXV : m_lo;
                    e_per = e_hw + e_lw;
                    e_sat = (m_hi > MAXV || m_lo > MAXV) ? 1 : 0;
                    e_mv  = 1'b1;
                    e_pc  = (e_pc + 1) % 65536;
                end
                m_busy = 1; m_high = 1; m_hi = 1; m_lo = 0;
            end else if (m_busy && m_high) begin
                if (!s && s_d) begin m_high = 0; m_lo = 1; end
                else m_hi++;
            end else if (m_busy) begin
                m_lo++;
            end
        end
        e_busy = m_busy ? 1 : 0;
    endtask

    task automatic tick(input bit sig, input bit r);
        bus.signal = sig;
        rst        = r;
        @(posedge clk);
        model_edge(sig, r);
        @(negedge clk);
        cyc++;
        chk("meas_valid",  int'(bus.meas_valid), int'(e_mv));
        chk("high_width",  int'(bus.high_width), e_hw);
        chk("low_width",   int'(bus.low_width), e_lw);
        chk("period",      int'(bus.period), e_per);
        chk("sat",         int'(bus.sat), e_sat);
        chk("pulse_count", int'(bus.pulse_count), e_pc);
        chk("busy",        int'(bus.busy), e_busy);
        if (bus.meas_valid === 1'b1)
            cap_q.push_back('{int'(bus.high_width), int'(bus.low_width),
                              int'(bus.period), int'(bus.sat), cyc});
    endtask

    task automatic run(input bit sig, input int n, input bit r = 1'b0);
        for (int i = 0; i < n; i++) tick(sig, r);
    endtask

    task automatic fresh_start();
        run(1'b0, 3, 1'b1);
        run(1'b0, 5);
        cap_q.delete();
    endtask

    initial begin
        vecs[0] = '{4, 6, 4, 6, 10, 0};
        vecs[1] = '{1, 1, 1, 1, 2, 0};
        vecs[2] = '{20, 2, 15, 2, 17, 1};
        vecs[3] = '{4, 6, 4, 6, 10, 0};
        vecs[4] = '{2, 18, 2, 15, 17, 1};
        vecs[5] = '{16, 1, 15, 1, 16, 1};
        vecs[6] = '{3, 5, 3, 5, 8, 0};

        rst        = 1'b1;
        bus.signal = 1'b0;
        @(negedge clk);

        // Reset held with the input toggling
        for (int i = 0; i < 3; i++) tick(i[0], 1'b1);
        chk("t1_no_strobe", cap_q.size(), 0);
        chk("t1_busy", int'(bus.busy), 0);
        chk("t1_pcount", int'(bus.pulse_count), 0);

        // 40/60 pulse repeated three times
        fresh_start();
        for (int i = 0; i < 3; i++) begin run(1'b1, 4); run(1'b0, 6); end
        run(1'b0, 5);
        chk("t2_strobes", cap_q.size(), 2);
        foreach (cap_q[k]) begin
            chk("t2_hw", cap_q[k].hw, 4);
            chk("t2_lw", cap_q[k].lw, 6);
            chk("t2_per", cap_q[k].per, 10);
            chk("t2_sat", cap_q[k].sat, 0);
        end
        chk("t2_pcount", int'(bus.pulse_count), 2);

        // Input high at reset release
        run(1'b1, 3, 1'b1);
        cap_q.delete();
        run(1'b1, 5);
        chk("t3_busy_idle", int'(bus.busy), 0);
        run(1'b0, 3);
        run(1'b1, 4);
        chk("t3_busy_meas", int'(bus.busy), 1);
        run(1'b0, 3);
        chk("t3_no_early", cap_q.size(), 0);
        run(1'b1, 4);
        chk("t3_strobes", cap_q.size(), 1);
        if (cap_q.size() == 1) begin
            chk("t3_hw", cap_q[0].hw, 4);
            chk("t3_lw", cap_q[0].lw, 3);
        end

        // Table of phases, including saturation and recovery
        fresh_start();
        foreach (vecs[k]) begin run(1'b1, vecs[k].hi); run(1'b0, vecs[k].lo); end
        run(1'b1, 3);
        run(1'b0, 3);
        chk("tab_strobes", cap_q.size(), 7);
        foreach (vecs[k]) begin
            if (k < cap_q.size()) begin
                chk("tab_hw", cap_q[k].hw, vecs[k].hw);
                chk("tab_lw", cap_q[k].lw, vecs[k].lw);
                chk("tab_per", cap_q[k].per, vecs[k].per);
                chk("tab_sat", cap_q[k].sat, vecs[k].sat);
            end
        end

        // Fastest legal train: 1 high, 1 low
        fresh_start();
        for (int i = 0; i < 8; i++) begin run(1'b1, 1); run(1'b0, 1); end
        run(1'b0, 4);
        chk("t5_strobes", cap_q.size(), 7);
        foreach (cap_q[k]) begin
            chk("t5_per", cap_q[k].per, 2);
            if (k > 0) chk("t5_spacing", cap_q[k].cyc - cap_q[k-1].cyc, 2);
        end
        chk("t5_pcount", int'(bus.pulse_count), 7);

        // Reset in the middle of a low phase
        fresh_start();
        run(1'b1, 5); run(1'b0, 3); run(1'b1, 5); run(1'b0, 5);
        chk("t6_busy_pre", int'(bus.busy), 1);
        chk("t6_pcount_pre", int'(bus.pulse_count), 1);
        run(1'b0, 2, 1'b1);
        chk("t6_pcount_rst", int'(bus.pulse_count), 0);
        chk("t6_busy_rst", int'(bus.busy), 0);
        cap_q.delete();
        run(1'b0, 4); run(1'b1, 3); run(1'b0, 2);
        chk("t6_no_strobe", cap_q.size(), 0);
        run(1'b1, 3); run(1'b0, 3);
        chk("t6_strobes", cap_q.size(), 1);
        if (cap_q.size() == 1) begin
            chk("t6_hw", cap_q[0].hw, 3);
            chk("t6_lw", cap_q[0].lw, 2);
        end
        chk("t6_pcount", int'(bus.pulse_count), 1);

        // Randomized trains with occasional resets
        fresh_start();
        for (int p = 0; p < 150; p++) begin
            run(1'b1, int'($urandom_range(1, 20)));
            run(1'b0, int'($urandom_range(1, 20)));
            if ($urandom_range(0, 14) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                    tick(1'($urandom_range(0, 1)), 1'b1);
            end
        end
        run(1'b0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
